// File: rtl/round_robin_arbiter4to1.sv
// Round-robin arbiter for a shared 4:1 mux datapath: grants one requester at a
// time, holds the grant for at most MAX_HOLD beats, then rotates priority.
module round_robin_arbiter4to1 #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       ready,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [3:0]       gnt_d;
  logic [1:0]       sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beat;
  logic             rel;
  logic [1:0]       nptr;
  logic [2:0]       win;

  // Rotating search from p; result is {found, index}, lowest offset wins.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [2:0] res;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign valid = |(gnt & req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt     <= '0;
      sel     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sel_d   = sel;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    beat    = 1'b0;
    rel     = 1'b0;
    nptr    = ptr_q;
    win     = '0;
    case (state_q)
      IDLE: begin
        win = pick(req, ptr_q);
        if (win[2]) begin
          state_d = GRANT;
          gnt_d   = 4'(1) << win[1:0];
          sel_d   = win[1:0];
          cnt_d   = '0;
        end
      end
      GRANT: begin
        beat = valid && ready;
        rel  = !req[sel] || (beat && (cnt_q == LAST_BEAT));
        if (rel) begin
          // Re-arbitrate at the release edge so a waiting requester sees no bubble.
          nptr  = sel + 2'd1;
          ptr_d = nptr;
          win   = pick(req, nptr);
          cnt_d = '0;
          if (win[2]) begin
            gnt_d = 4'(1) << win[1:0];
            sel_d = win[1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
